// File: rtl/hack_pkg.sv
// Shared constants, region decode and framebuffer entry type for the Hack data-port memory map.
package hack_pkg;

    localparam int DATA_W = 16;
    localparam logic [15:0] SCREEN_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR = 16'h6000;
    localparam int RAM_WORDS = 16384;
    localparam int SCREEN_WORDS = 8192;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } mem_region_e;

    typedef struct packed {
        logic [12:0] addr;
        logic [DATA_W-1:0] data;
    } fb_entry_t;

    // Bit 15 of the CPU address is don't-care.
    function automatic mem_region_e decode_region(input logic [15:0] addr);
        logic [15:0] a;
        a = {1'b0, addr[14:0]};
        if (a < SCREEN_BASE) return REG_RAM;
        else if (a < KBD_ADDR) return REG_SCREEN;
        else if (a == KBD_ADDR) return REG_KBD;
        else return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock FIFO of arbitrary entry type; a push while full is accepted only alongside a pop.
module hack_sync_fifo #(
    parameter type T = logic [7:0],
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic do_push;
    logic do_pop;

    assign empty = (count == '0);
    assign full = (count == (AW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: count <= count + 1'b1;
                2'b01: count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_mem_map.sv
// Hack CPU data-port responder: RAM, screen and keyboard decode with registered reads.
// HACK_SCREEN_FIFO_EN selects a queued valid/ready framebuffer port instead of a one-cycle pulse.
module hack_mem_map
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      addressM,
    input  logic [WIDTH-1:0] outM,
    input  logic             writeM,
    output logic [WIDTH-1:0] inM,
    input  logic [WIDTH-1:0] kbd_code,
    output logic             fb_valid,
    input  logic             fb_ready,
    output logic [12:0]      fb_addr,
    output logic [WIDTH-1:0] fb_data,
    output logic             fb_overflow
);
    logic [WIDTH-1:0] ram [RAM_WORDS];
    logic [WIDTH-1:0] screen [SCREEN_WORDS];
    logic [WIDTH-1:0] kbd_reg;
    mem_region_e region;
    logic scr_wr;

    assign region = decode_region(addressM);
    assign scr_wr = writeM && (region == REG_SCREEN);

    // Arrays carry no reset so their contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (writeM && (region == REG_RAM)) ram[addressM[13:0]] <= outM;
        if (scr_wr) screen[addressM[12:0]] <= outM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inM <= '0;
            kbd_reg <= '0;
        end else begin
            kbd_reg <= kbd_code;
            case (region)
                REG_RAM:    inM <= ram[addressM[13:0]];
                REG_SCREEN: inM <= screen[addressM[12:0]];
                REG_KBD:    inM <= kbd_reg;
                default:    inM <= '0;
            endcase
        end
    end

`ifdef HACK_SCREEN_FIFO_EN
    fb_entry_t push_entry;
    fb_entry_t head;
    logic fifo_full;
    logic fifo_empty;
    logic unused_addr;

    assign unused_addr = addressM[15];
    assign push_entry.addr = addressM[12:0];
    assign push_entry.data = outM;

    hack_sync_fifo #(
        .T(fb_entry_t),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(scr_wr),
        .push_data(push_entry),
        .pop(fb_ready),
        .pop_data(head),
        .full(fifo_full),
        .empty(fifo_empty)
    );

    assign fb_valid = !fifo_empty;
    assign fb_addr = head.addr;
    assign fb_data = head.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fb_overflow <= 1'b0;
        else if (scr_wr && fifo_full && !fb_ready) fb_overflow <= 1'b1;
    end
`else
    logic unused_in;

    assign unused_in = ^{fb_ready, addressM[15]};
    assign fb_overflow = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_valid <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_valid <= scr_wr;
            if (scr_wr) begin
                fb_addr <= addressM[12:0];
                fb_data <= outM;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hack_mem_map.sv
// Bench for hack_mem_map: directed plan steps plus random traffic against a queue/array model.
module tb_hack_mem_map;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addressM = '0;
    logic [15:0] outM = '0;
    logic        writeM = 1'b0;
    logic [15:0] inM;
    logic [15:0] kbd_code = '0;
    logic        fb_valid;
    logic        fb_ready = 1'b0;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_overflow;

    hack_mem_map #(.WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
        .inM(inM), .kbd_code(kbd_code), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_overflow(fb_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [15:0] mem_m [int];
    logic [15:0] kbd_m = '0;
    logic        ovf_m = 1'b0;
    int          q_a [$];
    logic [15:0] q_d [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 RAM, 1 SCREEN, 2 KBD, 3 NONE
    function automatic int region_of(input logic [15:0] a);
        int v;
        v = int'(a[14:0]);
        if (v < 16384) return 0;
        if (v < 24576) return 1;
        if (v == 24576) return 2;
        return 3;
    endfunction

    // One bus cycle: drive, predict from the model, take the edge, compare.
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input logic [15:0] k, input logic rdy);
        int r;
        int idx;
        logic known;
        logic [15:0] exp_in;
        addressM = a; outM = d; writeM = we; kbd_code = k; fb_ready = rdy;
        r = region_of(a);
        idx = int'(a[14:0]);
        known = 1'b1;
        exp_in = '0;
        if (r <= 1) begin
            if (mem_m.exists(idx)) exp_in = mem_m[idx];
            else known = 1'b0;
        end else if (r == 2) exp_in = kbd_m;
        if (we && r <= 1) mem_m[idx] = d;
        kbd_m = k;
`ifdef HACK_SCREEN_FIFO_EN
        if (rdy && q_a.size() > 0) begin
            void'(q_a.pop_front());
            void'(q_d.pop_front());
        end
        if (we && r == 1) begin
            if (q_a.size() < DEPTH) begin
                q_a.push_back(idx - 16384);
                q_d.push_back(d);
            end else ovf_m = 1'b1;
        end
`else
        q_a.delete();
        q_d.delete();
        if (we && r == 1) begin
            q_a.push_back(idx - 16384);
            q_d.push_back(d);
        end
`endif
        @(posedge clk);
        #1;
        if (known) check("inM", 32'(inM), 32'(exp_in));
        check("fb_valid", 32'(fb_valid), 32'(q_a.size() > 0));
        if (q_a.size() > 0) begin
            check("fb_addr", 32'(fb_addr), 32'(q_a[0]));
            check("fb_data", 32'(fb_data), 32'(q_d[0]));
        end
        check("fb_overflow", 32'(fb_overflow), 32'(ovf_m));
    endtask

    task automatic do_reset(input logic imm);
        writeM = 1'b0;
        reset = 1'b1;
        #1;
        if (imm) begin
            check("rst_imm_inM", 32'(inM), 32'h0);
            check("rst_imm_valid", 32'(fb_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        check("rst_inM", 32'(inM), 32'h0);
        check("rst_valid", 32'(fb_valid), 32'h0);
        check("rst_ovf", 32'(fb_overflow), 32'h0);
        kbd_m = '0;
        ovf_m = 1'b0;
        q_a.delete();
        q_d.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] pool [10];
        do_reset(1'b0);

        // RAM round trip and read-first
        cyc(16'h0011, 16'hBEEF, 1'b1, 16'h0, 1'b1);
        cyc(16'h0010, 16'h1234, 1'b1, 16'h0, 1'b1);
        cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b1);
        check("ram_rd_0010", 32'(inM), 32'h1234);
        cyc(16'h0011, 16'h0, 1'b0, 16'h0, 1'b1);
        check("ram_rd_0011", 32'(inM), 32'hBEEF);
        cyc(16'h0011, 16'h5555, 1'b1, 16'h0, 1'b1);
        check("ram_read_first", 32'(inM), 32'hBEEF);
        cyc(16'h0011, 16'h0, 1'b0, 16'h0, 1'b1);
        check("ram_after_wr", 32'(inM), 32'h5555);

        // Screen path
        cyc(16'h4005, 16'hFFFF, 1'b1, 16'h0, 1'b1);
        check("scr_valid", 32'(fb_valid), 32'h1);
        check("scr_addr", 32'(fb_addr), 32'h0005);
        check("scr_data", 32'(fb_data), 32'hFFFF);
        cyc(16'h4005, 16'h0, 1'b0, 16'h0, 1'b1);
        check("scr_rd", 32'(inM), 32'hFFFF);
        check("scr_valid_drop", 32'(fb_valid), 32'h0);

        // Keyboard: two-edge visibility, writes ignored
        cyc(16'h6000, 16'h0, 1'b0, 16'h0041, 1'b1);
        cyc(16'h6000, 16'h0, 1'b0, 16'h0041, 1'b1);
        check("kbd_41", 32'(inM), 32'h0041);
        cyc(16'h6000, 16'h0, 1'b0, 16'h0, 1'b1);
        cyc(16'h6000, 16'h0, 1'b0, 16'h0, 1'b1);
        check("kbd_0", 32'(inM), 32'h0);
        cyc(16'h6000, 16'h7777, 1'b1, 16'h0, 1'b1);
        cyc(16'h6000, 16'h0, 1'b0, 16'h0, 1'b1);
        check("kbd_wr_ignored", 32'(inM), 32'h0);
        check("kbd_wr_no_fb", 32'(fb_valid), 32'h0);

        // Unmapped and ignored bit 15
        cyc(16'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
        check("none_rd", 32'(inM), 32'h0);
        cyc(16'h6001, 16'h7777, 1'b1, 16'h0, 1'b1);
        cyc(16'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
        check("none_wr_ignored", 32'(inM), 32'h0);
        cyc(16'h8010, 16'h0, 1'b0, 16'h0, 1'b1);
        check("bit15_alias", 32'(inM), 32'h1234);

`ifdef HACK_SCREEN_FIFO_EN
        // Full plus simultaneous pop
        for (int i = 0; i < 4; i++) cyc(16'h4008 + 16'(i), 16'hA008 + 16'(i), 1'b1, 16'h0, 1'b0);
        check("full_no_ovf", 32'(fb_overflow), 32'h0);
        cyc(16'h400C, 16'hA00C, 1'b1, 16'h0, 1'b1);
        check("fullpop_ovf", 32'(fb_overflow), 32'h0);
        check("fullpop_head", 32'(fb_addr), 32'h0009);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_order", 32'(fb_addr), 32'(9 + i));
            cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b1);
        end
        check("fullpop_empty", 32'(fb_valid), 32'h0);

        // Overflow: five writes with no ready, exactly four survive
        for (int i = 0; i < 5; i++) cyc(16'h4000 + 16'(i), 16'hB000 + 16'(i), 1'b1, 16'h0, 1'b0);
        check("ovf_set", 32'(fb_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_order", 32'(fb_addr), 32'(i));
            check("ovf_data", 32'(fb_data), 32'(16'hB000 + 16'(i)));
            cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b1);
        end
        check("ovf_drained", 32'(fb_valid), 32'h0);
        check("ovf_sticky", 32'(fb_overflow), 32'h1);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) cyc(16'h4010 + 16'(i), 16'hC000, 1'b1, 16'h0, 1'b0);
`else
        cyc(16'h4007, 16'h1357, 1'b1, 16'h0, 1'b0);
        check("pulse_valid", 32'(fb_valid), 32'h1);
        check("pulse_addr", 32'(fb_addr), 32'h0007);
        cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b0);
        check("pulse_end", 32'(fb_valid), 32'h0);
        cyc(16'h4008, 16'h2468, 1'b1, 16'h0, 1'b0);
`endif
        cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b0);
        check("pre_rst_inM", 32'(inM), 32'h1234);
        do_reset(1'b1);
        cyc(16'h0010, 16'h0, 1'b0, 16'h0, 1'b1);
        check("ram_kept", 32'(inM), 32'h1234);

        // Random traffic
        pool = '{16'h0000, 16'h0003, 16'h3FFF, 16'h4000, 16'h4002,
                 16'h5FFF, 16'h6000, 16'h6001, 16'h7FFF, 16'h000A};
        for (int n = 0; n < 400; n++) begin
            a = pool[$urandom_range(0, 9)];
            if (a[14:13] != 2'b11) a[3:0] = 4'($urandom_range(0, 15));
            a[15] = 1'($urandom_range(0, 1));
            cyc(a, 16'($urandom), 1'($urandom_range(0, 2) == 0), 16'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_mem_map.md
# hack_mem_map

Memory-side responder for the Hack CPU data port. It decodes `addressM` into three regions: 16K-word data RAM, 8K-word screen RAM and the keyboard register. It returns registered read data on `inM` and performs writes qualified by `writeM`. Screen writes are also forwarded to the video framebuffer over a valid/ready port, buffered so the non-stalling CPU never waits.

## Interface
Parameters:
- `WIDTH`, 16, data word width.
- `FIFO_DEPTH`, 4, screen-write queue depth, power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `addressM`  in  16  CPU data address; bit 15 is ignored.
- `outM`  in  WIDTH  CPU write data.
- `writeM`  in  1  CPU write enable, one-cycle pulse.
- `inM`  out  WIDTH  registered read data.
- `kbd_code`  in  WIDTH  current key code, 0 when no key is pressed.
- `fb_valid`  out  1  screen-write entry available.
- `fb_ready`  in  1  framebuffer accepts the entry.
- `fb_addr`  out  13  screen word offset.
- `fb_data`  out  WIDTH  screen word.
- `fb_overflow`  out  1  sticky: a screen write was dropped.

## Operation
Decode uses `addressM[14:0]`:
- `0x0000–0x3FFF` is RAM, indexed by bits [13:0].
- `0x4000–0x5FFF` is SCREEN, indexed by bits [12:0].
- `0x6000` is KBD.
- Anything else is NONE.

Read path:
- `inM` is updated every cycle from the region selected by the current `addressM`.
- RAM and SCREEN return the word at the indexed location.
- KBD returns `kbd_reg`.
- NONE returns 0.

Write path, on `writeM`=1:
- RAM writes the RAM array.
- SCREEN writes the screen array and pushes {offset, `outM`} into the FIFO.
- KBD and NONE writes are dropped silently.

Keyboard: `kbd_reg` samples `kbd_code` every cycle.

FIFO:
- Pop occurs when `fb_valid && fb_ready`.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- A push while full with no pop drops the entry and sets `fb_overflow`.
- `fb_overflow` clears only on reset.
- Entries leave in push order.
- `fb_addr`/`fb_data` show the head entry and must stay stable while `fb_valid`=1 and `fb_ready`=0.

## Timing
Read latency:
- `inM` at edge N+1 reflects `addressM` at edge N, i.e. one cycle.
- The CPU holds A during FETCH, so `inM` is valid in EXEC.

Write commit:
- A write commits at the edge where `writeM`=1.
- Arrays are read-first: a same-cycle read of the written address returns the old data.
- The next cycle's read returns the new data.

Keyboard: a `kbd_code` change is visible on `inM` 2 edges later, given `addressM`=0x6000.

FIFO:
- A screen write at edge N gives `fb_valid`=1 after edge N if the FIFO was empty.
- No combinational path exists from `fb_ready` to `fb_valid`.

Reset values:
- `inM`=0, `kbd_reg`=0, `fb_valid`=0, `fb_overflow`=0.
- FIFO pointers and count are 0.
- RAM and screen contents are not reset.

Reset asserted mid-transfer empties the FIFO immediately and drops queued entries; array contents are preserved.

## Configuration
Macro `HACK_SCREEN_FIFO_EN`:
- **Defined:** screen writes use the FIFO, valid/ready and overflow behaviour described above.
- **Undefined:** no FIFO.
  - `fb_valid` is a registered one-cycle pulse carrying the write, one cycle after `writeM`.
  - `fb_ready` is ignored.
  - `fb_overflow` is tied to 0.

## Structure
Package `hack_pkg` holds:
- `SCREEN_BASE`=16'h4000, `KBD_ADDR`=16'h6000, `RAM_WORDS`=16384, `SCREEN_WORDS`=8192.
- Region enum `mem_region_e` {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE}.
- Struct `fb_entry_t` {addr[12:0], data}.

Sub-module `hack_sync_fifo`:
- Parameterized by entry type and depth.
- Provides push/pop/full/empty.
- Instantiated only under `HACK_SCREEN_FIFO_EN`.

Both arrays are inferred as single-port block RAM with registered output.

## Test plan
- **RAM round trip:** write 0x1234 to 0x0010, then read 0x0010 → `inM`=0x1234 one cycle later; read 0x0011 → prior contents unchanged.
- **Screen path:** write 0xFFFF to 0x4005 with `fb_ready`=1 → `fb_valid` pulses with `fb_addr`=0x0005, `fb_data`=0xFFFF; read 0x4005 → 0xFFFF.
- **Keyboard:**
  - `kbd_code`=0x0041 with `addressM`=0x6000 → `inM`=0x0041 after 2 cycles.
  - `kbd_code`=0 → `inM`=0.
  - Write 0x7777 to 0x6000 → no effect.
- **Overflow:** `fb_ready`=0, five screen writes to offsets 0–4 → `fb_overflow`=1; raise `fb_ready` → exactly offsets 0–3 emerge, in order.
- **Full plus simultaneous pop:** FIFO full and `fb_ready`=1 while a fifth write arrives → accepted, no overflow, count stays 4.
- **Unmapped and reset:**
  - Read 0x6001 → `inM`=0; write 0x6001 → nothing changes.
  - Assert `reset` with 3 entries queued → `fb_valid`=0 and `inM`=0 immediately.
  - RAM at 0x0010 still reads 0x1234 after reset.
